// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU run/load controller:
// control-word width, control-bit positions, fixed loader control
// words and the controller state encoding.
package cpu_pkg;

    localparam int unsigned CTRL_W = 15;

    // Control-word bit positions (names with an n prefix are active-low).
    localparam int unsigned CP   = 14;
    localparam int unsigned EP   = 13;
    localparam int unsigned LP   = 12;
    localparam int unsigned NLMA = 11;
    localparam int unsigned NLMD = 10;
    localparam int unsigned NCE  = 9;
    localparam int unsigned NLR  = 8;
    localparam int unsigned NLI  = 7;
    localparam int unsigned NEI  = 6;
    localparam int unsigned NLA  = 5;
    localparam int unsigned EA   = 4;
    localparam int unsigned SUB  = 3;
    localparam int unsigned EU   = 2;
    localparam int unsigned NLB  = 1;
    localparam int unsigned NLO  = 0;

    // All active-low strobes inactive, all active-high enables off.
    localparam logic [CTRL_W-1:0] CTRL_NOP = 15'h0FE3;

    // Loader words: NOP with exactly one active-low strobe pulled low.
    localparam logic [CTRL_W-1:0] CTRL_LOAD_ADDR  = CTRL_NOP & ~(CTRL_W'(1) << NLMA);
    localparam logic [CTRL_W-1:0] CTRL_LOAD_DATA  = CTRL_NOP & ~(CTRL_W'(1) << NLMD);
    localparam logic [CTRL_W-1:0] CTRL_LOAD_WRITE = CTRL_NOP & ~(CTRL_W'(1) << NLR);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_WAIT  = 3'd1,
        LOAD_ADDR  = 3'd2,
        LOAD_DATA  = 3'd3,
        LOAD_WRITE = 3'd4,
        RESTART    = 3'd5,
        RUN        = 3'd6,
        HALTED     = 3'd7
    } state_t;

endpackage

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: owns the control word between control_block and the
// datapath. Load mode writes a program into RAM byte by byte from a
// valid/ready stream (MAR load, MDR load, RAM write per byte) while holding
// the CPU in reset; run mode passes the control_block word through until halt.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load_req              level, request program load mode
//   run_req               pulse, (re)start execution from address 0
//   wr_valid/wr_data      program byte stream in
//   wr_ready              registered, byte accepted when high with wr_valid
//   cb_ctrl               control word from control_block
//   hlt                   halt opcode decoded
//   ctrl_out              control word to datapath (passthrough in RUN)
//   bus_out/bus_oe        loader bus value and drive enable
//   cpu_rst_n             registered active-low reset to PC/IR/control_block
//   cpu_ce                CPU clock enable
//   state                 current FSM state
//   load_count            bytes written since entering load mode
//
// Build option: define CPU_SINGLE_STEP_EN to add step_mode/step_req; with
// step_mode set, RUN only advances (and only honours hlt) when step_req is high.
module cpu_run_controller #(
    parameter int unsigned RAM_BYTES = 16,
    parameter int unsigned CTRL_W    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              run_req,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    input  logic [CTRL_W-1:0] cb_ctrl,
    input  logic              hlt,
`ifdef CPU_SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step_req,
`endif
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [7:0]        bus_out,
    output logic              bus_oe,
    output logic              cpu_rst_n,
    output logic              cpu_ce,
    output logic [2:0]        state,
    output logic [4:0]        load_count
);

    import cpu_pkg::state_t;
    import cpu_pkg::IDLE;
    import cpu_pkg::LOAD_WAIT;
    import cpu_pkg::LOAD_ADDR;
    import cpu_pkg::LOAD_DATA;
    import cpu_pkg::LOAD_WRITE;
    import cpu_pkg::RESTART;
    import cpu_pkg::RUN;
    import cpu_pkg::HALTED;
    import cpu_pkg::CTRL_NOP;
    import cpu_pkg::CTRL_LOAD_ADDR;
    import cpu_pkg::CTRL_LOAD_DATA;
    import cpu_pkg::CTRL_LOAD_WRITE;

    localparam int unsigned AW = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;
    localparam int unsigned CW = 5;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [7:0]        bus_q, bus_d;
    logic              oe_q, oe_d;
    logic              ready_q, ready_d;
    logic              rst_q, rst_d;
    logic              accept;
    logic              run_active;

    // A RUN cycle is "active" when the CPU actually advances this cycle.
`ifdef CPU_SINGLE_STEP_EN
    assign run_active = !step_mode || step_req;
`else
    assign run_active = 1'b1;
`endif

    // ready_q is only ever high in LOAD_WAIT, so this is the stream handshake.
    assign accept = wr_valid && ready_q;

    // State register plus registered outputs (loaded from next-state decode).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            ctrl_q  <= CTRL_W'(CTRL_NOP);
            bus_q   <= '0;
            oe_q    <= 1'b0;
            ready_q <= 1'b0;
            rst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            bus_q   <= bus_d;
            oe_q    <= oe_d;
            ready_q <= ready_d;
            rst_q   <= rst_d;
        end
    end

    // Next-state logic, then output values for the state being entered.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        data_d  = data_q;
        ctrl_d  = CTRL_W'(CTRL_NOP);
        bus_d   = '0;
        oe_d    = 1'b0;
        ready_d = 1'b0;
        rst_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d = LOAD_WAIT;
                    addr_d  = '0;
                    count_d = '0;
                end else if (run_req) begin
                    state_d = RESTART;
                end
            end
            LOAD_WAIT: begin
                // An offered-and-ready byte is always taken, even if load_req
                // dropped in the same cycle; the source already saw ready.
                if (accept) begin
                    data_d  = wr_data;
                    state_d = LOAD_ADDR;
                end else if (!load_req) begin
                    state_d = IDLE;
                end
            end
            LOAD_ADDR:  state_d = LOAD_DATA;
            LOAD_DATA:  state_d = LOAD_WRITE;
            LOAD_WRITE: begin
                addr_d  = (addr_q == AW'(RAM_BYTES - 1)) ? '0 : addr_q + 1'b1;
                count_d = count_q + 1'b1;
                state_d = LOAD_WAIT;
            end
            RESTART: state_d = RUN;
            RUN: begin
                if (load_req) begin
                    state_d = IDLE;
                end else if (hlt && run_active) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (load_req) begin
                    state_d = IDLE;
                end else if (run_req) begin
                    state_d = RESTART;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            LOAD_WAIT: ready_d = (count_d < CW'(RAM_BYTES));
            LOAD_ADDR: begin
                bus_d  = 8'(addr_d);
                oe_d   = 1'b1;
                ctrl_d = CTRL_W'(CTRL_LOAD_ADDR);
            end
            LOAD_DATA: begin
                bus_d  = data_d;
                oe_d   = 1'b1;
                ctrl_d = CTRL_W'(CTRL_LOAD_DATA);
            end
            LOAD_WRITE: ctrl_d = CTRL_W'(CTRL_LOAD_WRITE);
            RUN, HALTED: rst_d = 1'b1;
            default: ;
        endcase
    end

    // RUN hands the control word and clock enable straight to control_block.
    assign ctrl_out   = (state_q == RUN && run_active) ? cb_ctrl : ctrl_q;
    assign cpu_ce     = (state_q == RUN) && run_active;
    assign bus_out    = bus_q;
    assign bus_oe     = oe_q;
    assign wr_ready   = ready_q;
    assign cpu_rst_n  = rst_q;
    assign state      = state_q;
    assign load_count = count_q;

endmodule
